// File: rtl/reg_file_sb.sv
// Integer register file with a per-register busy scoreboard feeding the ALU operands.
// Define RF_BYPASS_EN to forward same-cycle write-back data to the read ports.
module reg_file_sb #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned NREG   = 32,
  parameter int unsigned ADDR_W = 5
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [ADDR_W-1:0] rs1,
  input  logic [ADDR_W-1:0] rs2,
  output logic [DATA_W-1:0] rd1,
  output logic [DATA_W-1:0] rd2,
  input  logic              iss_en,
  input  logic [ADDR_W-1:0] iss_rd,
  input  logic              wb_en,
  input  logic [ADDR_W-1:0] wb_rd,
  input  logic [DATA_W-1:0] wb_data,
  output logic              stall
);

  logic [DATA_W-1:0] regs_q [NREG];
  logic [DATA_W-1:0] regs_d [NREG];
  logic [NREG-1:0]   busy_q, busy_d;
  logic              hit1, hit2;

  always_comb begin
    regs_d = regs_q;
    busy_d = busy_q;
    for (int unsigned i = 1; i < NREG; i++) begin
      if (wb_en && (wb_rd == ADDR_W'(i))) begin
        regs_d[i] = wb_data;
      end
      // A new issue wins over a retiring write-back: the new producer is still outstanding.
      if (iss_en && (iss_rd == ADDR_W'(i))) begin
        busy_d[i] = 1'b1;
      end else if (wb_en && (wb_rd == ADDR_W'(i))) begin
        busy_d[i] = 1'b0;
      end
    end
    regs_d[0] = '0;
    busy_d[0] = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < NREG; i++) begin
        regs_q[i] <= '0;
      end
      busy_q <= '0;
    end else begin
      regs_q <= regs_d;
      busy_q <= busy_d;
    end
  end

`ifdef RF_BYPASS_EN
  assign hit1 = wb_en && (wb_rd == rs1) && (rs1 != '0);
  assign hit2 = wb_en && (wb_rd == rs2) && (rs2 != '0);
`else
  assign hit1 = 1'b0;
  assign hit2 = 1'b0;
`endif

  always_comb begin
    rd1 = '0;
    rd2 = '0;
    if (hit1) begin
      rd1 = wb_data;
    end else if (rs1 != '0) begin
      rd1 = regs_q[rs1];
    end
    if (hit2) begin
      rd2 = wb_data;
    end else if (rs2 != '0) begin
      rd2 = regs_q[rs2];
    end
  end

  assign stall = ((rs1 != '0) && busy_q[rs1] && !hit1) ||
                 ((rs2 != '0) && busy_q[rs2] && !hit2);

endmodule

// File: tb/tb_reg_file_sb.sv
// Directed vector bench for reg_file_sb; expectations follow whichever build
// (RF_BYPASS_EN defined or not) is compiled.
module tb_reg_file_sb;

  logic        clk;
  logic        rst_n;
  logic [4:0]  rs1, rs2, iss_rd, wb_rd;
  logic [31:0] rd1, rd2, wb_data;
  logic        iss_en, wb_en, stall;

  int unsigned n_pass;
  int unsigned n_total;

  reg_file_sb #(
    .DATA_W(32),
    .NREG  (32),
    .ADDR_W(5)
  ) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .rs1    (rs1),
    .rs2    (rs2),
    .rd1    (rd1),
    .rd2    (rd2),
    .iss_en (iss_en),
    .iss_rd (iss_rd),
    .wb_en  (wb_en),
    .wb_rd  (wb_rd),
    .wb_data(wb_data),
    .stall  (stall)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic        iss_en;
    logic [4:0]  iss_rd;
    logic        wb_en;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;
    logic [31:0] exp_rd1;
    logic [31:0] exp_rd2;
    logic        exp_stall;
  } vec_t;

  localparam int NVEC = 15;
  vec_t vecs [NVEC];

`ifdef RF_BYPASS_EN
  localparam bit Byp = 1'b1;
`else
  localparam bit Byp = 1'b0;
`endif

  function automatic vec_t mk(string name, logic [4:0] r1, logic [4:0] r2,
                              logic ie, logic [4:0] ird, logic we, logic [4:0] wrd,
                              logic [31:0] wd, logic [31:0] e1, logic [31:0] e2,
                              logic es);
    vec_t v;
    v.name = name; v.rs1 = r1; v.rs2 = r2; v.iss_en = ie; v.iss_rd = ird;
    v.wb_en = we; v.wb_rd = wrd; v.wb_data = wd;
    v.exp_rd1 = e1; v.exp_rd2 = e2; v.exp_stall = es;
    return v;
  endfunction

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    n_total++;
    if (act === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic drive_idle();
    rs1 = '0; rs2 = '0; iss_en = 1'b0; iss_rd = '0;
    wb_en = 1'b0; wb_rd = '0; wb_data = '0;
  endtask

  initial begin
    n_pass  = 0;
    n_total = 0;
    rst_n   = 1'b0;
    drive_idle();

    // Inputs change on the falling edge and are checked 1 ns later, well before the rising edge.
    vecs[0]  = mk("reset_read",   5'd3,  5'd0, 0, 5'd0,  0, 5'd0,  32'h0,
                  32'h0, 32'h0, 0);
    vecs[1]  = mk("wb_x0",        5'd0,  5'd0, 0, 5'd0,  1, 5'd0,  32'hDEADBEEF,
                  32'h0, 32'h0, 0);
    vecs[2]  = mk("x0_after_wb",  5'd0,  5'd0, 1, 5'd0,  0, 5'd0,  32'h0,
                  32'h0, 32'h0, 0);
    vecs[3]  = mk("x0_no_busy",   5'd0,  5'd0, 1, 5'd7,  0, 5'd0,  32'h0,
                  32'h0, 32'h0, 0);
    vecs[4]  = mk("x7_busy",      5'd7,  5'd0, 0, 5'd0,  0, 5'd0,  32'h0,
                  32'h0, 32'h0, 1);
    vecs[5]  = mk("x7_wb_cycle",  5'd7,  5'd0, 0, 5'd0,  1, 5'd7,  32'h42,
                  Byp ? 32'h42 : 32'h0, 32'h0, !Byp);
    vecs[6]  = mk("x7_after_wb",  5'd7,  5'd0, 0, 5'd0,  0, 5'd0,  32'h0,
                  32'h42, 32'h0, 0);
    vecs[7]  = mk("x9_iss_wb",    5'd0,  5'd9, 1, 5'd9,  1, 5'd9,  32'h55,
                  32'h0, Byp ? 32'h55 : 32'h0, 0);
    vecs[8]  = mk("x9_still_busy",5'd0,  5'd9, 0, 5'd0,  0, 5'd0,  32'h0,
                  32'h0, 32'h55, 1);
    vecs[9]  = mk("wb_x31",       5'd0,  5'd0, 0, 5'd0,  1, 5'd31, 32'hFFFFFFFF,
                  32'h0, 32'h0, 0);
    vecs[10] = mk("wb_x1",        5'd31, 5'd0, 0, 5'd0,  1, 5'd1,  32'h80000000,
                  32'hFFFFFFFF, 32'h0, 0);
    vecs[11] = mk("rd_31_1",      5'd31, 5'd1, 0, 5'd0,  0, 5'd0,  32'h0,
                  32'hFFFFFFFF, 32'h80000000, 0);
    vecs[12] = mk("rd_31_31",     5'd31, 5'd31,0, 5'd0,  0, 5'd0,  32'h0,
                  32'hFFFFFFFF, 32'hFFFFFFFF, 0);
    vecs[13] = mk("wb_x5",        5'd5,  5'd0, 0, 5'd0,  1, 5'd5,  32'h1234,
                  Byp ? 32'h1234 : 32'h0, 32'h0, 0);
    vecs[14] = mk("rd_x5",        5'd5,  5'd0, 0, 5'd0,  0, 5'd0,  32'h0,
                  32'h1234, 32'h0, 0);

    repeat (2) @(posedge clk);
    #1;
    chk("reset_rd1", rd1, 32'h0);
    chk("reset_stall", {31'h0, stall}, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < NVEC; i++) begin
      @(negedge clk);
      rs1 = vecs[i].rs1; rs2 = vecs[i].rs2;
      iss_en = vecs[i].iss_en; iss_rd = vecs[i].iss_rd;
      wb_en = vecs[i].wb_en; wb_rd = vecs[i].wb_rd; wb_data = vecs[i].wb_data;
      #1;
      chk({vecs[i].name, ".rd1"}, rd1, vecs[i].exp_rd1);
      chk({vecs[i].name, ".rd2"}, rd2, vecs[i].exp_rd2);
      chk({vecs[i].name, ".stall"}, {31'h0, stall}, {31'h0, vecs[i].exp_stall});
    end

    // Asynchronous reset mid-cycle: x5 and busy x9 must clear without a clock edge.
    @(negedge clk);
    drive_idle();
    rs1 = 5'd5; rs2 = 5'd9;
    #1;
    chk("pre_rst_rd1", rd1, 32'h1234);
    chk("pre_rst_stall", {31'h0, stall}, 32'h1);
    #1;
    rst_n = 1'b0;
    #1;
    chk("async_rst_rd1", rd1, 32'h0);
    chk("async_rst_rd2", rd2, 32'h0);
    chk("async_rst_stall", {31'h0, stall}, 32'h0);

    // Reset held across an edge with a write and an issue pending: reset must win.
    wb_en = 1'b1; wb_rd = 5'd5; wb_data = 32'hCAFEF00D;
    iss_en = 1'b1; iss_rd = 5'd9;
    @(posedge clk);
    #1;
    chk("rst_prio_rd1", rd1, 32'h0);
    chk("rst_prio_stall", {31'h0, stall}, 32'h0);
    @(negedge clk);
    drive_idle();
    rs1 = 5'd5; rs2 = 5'd9;
    rst_n = 1'b1;
    #1;
    chk("post_rst_rd1", rd1, 32'h0);
    chk("post_rst_stall", {31'h0, stall}, 32'h0);

    // Write-back to a non-busy register leaves it non-busy.
    @(negedge clk);
    wb_en = 1'b1; wb_rd = 5'd9; wb_data = 32'h0000ABCD;
    @(negedge clk);
    drive_idle();
    rs1 = 5'd0; rs2 = 5'd9;
    #1;
    chk("wb_nonbusy_rd2", rd2, 32'h0000ABCD);
    chk("wb_nonbusy_stall", {31'h0, stall}, 32'h0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: got no finish, expected finish before 100000 ns");
    $fatal(1);
  end

endmodule

// File: doc/reg_file_sb.md
Name: reg_file_sb

Overview:
- Integer register file with scoreboard.
- Sits directly upstream of the ALU: read ports rd1/rd2 drive ALU operands a/b, and the write-back port takes ALU results (or load data).
- The scoreboard tracks registers with an outstanding write.
- It raises stall when a source operand is not yet valid, so the control unit holds the instruction.

Parameters:
- DATA_W, 32, register width in bits.
- NREG, 32, number of architectural registers (x0..x31).
- ADDR_W, 5, register index width; must satisfy 2**ADDR_W == NREG.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- rs1  input  ADDR_W  source register 1 index.
- rs2  input  ADDR_W  source register 2 index.
- rd1  output  DATA_W  value of rs1 (to ALU a).
- rd2  output  DATA_W  value of rs2 (to ALU b).
- iss_en  input  1  instruction issued this cycle that will write iss_rd.
- iss_rd  input  ADDR_W  destination of the issued instruction.
- wb_en  input  1  write-back valid this cycle.
- wb_rd  input  ADDR_W  write-back destination.
- wb_data  input  DATA_W  write-back value.
- stall  output  1  rs1 or rs2 has a pending write not satisfied this cycle.

Behaviour:
- Reset (rst_n low, asynchronous, any time including mid-write):
  - all registers cleared to 0 and all busy bits cleared.
  - rd1 = rd2 = 0, stall = 0.
  - Reset takes priority over any same-edge write or issue.
- State: regs[NREG] of DATA_W bits, busy[NREG] of 1 bit.
- Reads are combinational, zero latency: rd1 = regs[rs1], rd2 = regs[rs2], subject to the x0 rule and the optional bypass.
- x0 rule:
  - Index 0 always reads 0.
  - Writes to 0 are discarded.
  - busy[0] is never set.
  - rs=0 never causes stall.
- Write:
  - On a rising edge with wb_en=1 and wb_rd!=0, regs[wb_rd] <= wb_data.
  - The new value is visible on rd1/rd2 the cycle after the edge.
- Busy update at each rising edge, evaluated per index:
  - set if iss_en=1 and iss_rd==index and index!=0;
  - else cleared if wb_en=1 and wb_rd==index;
  - else hold.
  - Issue and write-back to the same index on the same edge: busy stays 1, because the new producer is outstanding. The register data is still written.
- Stall, combinational: stall = (rs1!=0 & busy[rs1] & ~hit1) | (rs2!=0 & busy[rs2] & ~hit2).
  - hit1/hit2 are defined only when the optional feature is on; otherwise they are 0.
- Write-back to a non-busy register is legal: data is written and busy stays 0.
- iss_en while stall=1 is a protocol error upstream; the block still sets busy as specified and no checking is done.
- No internal reset of busy other than rst_n and write-back; the control unit must not issue the same rd twice without an intervening write-back, or the first write-back clears busy early.

Optional Feature:
- Macro: RF_BYPASS_EN.
- Defined:
  - hitN = wb_en & (wb_rd==rsN) & (rsN!=0).
  - On a hit, rdN = wb_data in the same cycle (write-through), and that operand does not contribute to stall.
- Undefined:
  - rdN returns the old regs[rsN] during the write-back cycle.
  - stall stays asserted for that operand until the edge that clears busy, so there is a one-cycle stall penalty per dependent read.

Test Plan:
1. Reset, then rs1=3, rs2=0 → rd1=0, rd2=0, stall=0. Assert rst_n low mid-run after writing x5=0x1234 → rd of x5 reads 0 immediately, without waiting for a clock.
2. wb_en=1, wb_rd=0, wb_data=0xDEADBEEF; next cycle rs1=0 → rd1=0. iss_en=1 with iss_rd=0 → stall stays 0 with rs1=0.
3. iss_en=1, iss_rd=7 at edge; next cycle rs1=7 → stall=1. Then wb_en=1, wb_rd=7, wb_data=0x00000042:
   - bypass build: rd1=0x42 and stall=0 in the same cycle;
   - non-bypass build: stall=1 and rd1 shows the old value, then stall=0 and rd1=0x42 after the edge.
4. Same edge iss_en=1, iss_rd=9 and wb_en=1, wb_rd=9, wb_data=0x55 → regs[9]=0x55, busy[9] stays 1, and rs2=9 gives stall=1 next cycle.
5. Write x31=0xFFFFFFFF and x1=0x80000000; read rs1=31, rs2=1 → rd1=0xFFFFFFFF, rd2=0x80000000. This exercises the top index and MSB. Also check that rs1=rs2=31 returns the same value on both ports.
